// File: rtl/cios_pkg.sv
// Shared types for the CIOS row engine: row mode, FSM states and default sizes.
package cios_pkg;

  localparam int CIOS_WIDTH     = 16;
  localparam int CIOS_NUM_WORDS = 8;

  typedef logic [CIOS_WIDTH-1:0]   word_t;
  typedef logic [2*CIOS_WIDTH-1:0] dword_t;

  typedef enum logic {
    CIOS_MUL = 1'b0,
    CIOS_RED = 1'b1
  } cios_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    TAIL = 2'd2,
    DONE = 2'd3
  } row_state_e;

endpackage

// File: rtl/cios_word_mac.sv
// Combinational word cell: {c_o, s_o} = t_i + x_i * y_i + c_i in 2*WIDTH bits.
module cios_word_mac #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] t_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH-1:0] c_i,
  output logic [WIDTH-1:0] s_o,
  output logic [WIDTH-1:0] c_o
);

  logic [2*WIDTH-1:0] sum;

  // Double-width multiply-accumulate; the worst case is exactly 2^(2W)-1 so nothing is lost
  always_comb begin
    sum = {{WIDTH{1'b0}}, t_i}
        + ({{WIDTH{1'b0}}, x_i} * {{WIDTH{1'b0}}, y_i})
        + {{WIDTH{1'b0}}, c_i};
  end

  assign s_o = sum[WIDTH-1:0];
  assign c_o = sum[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/cios_row_engine.sv
// One CIOS inner-loop row (multiply or reduction) over NUM_WORDS streamed words.
module cios_row_engine
  import cios_pkg::*;
#(
  parameter int WIDTH     = CIOS_WIDTH,
  parameter int NUM_WORDS = CIOS_NUM_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] scalar,
  input  logic [WIDTH-1:0] t_s,
  input  logic [WIDTH-1:0] t_s1,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] top_lo,
  output logic [WIDTH-1:0] top_hi
);

  localparam int              IDX_W    = $clog2(NUM_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  row_state_e       state_q, state_d;
  cios_mode_e       mode_q, mode_d;
  logic [WIDTH-1:0] scalar_q, scalar_d;
  logic [WIDTH-1:0] tS_q, tS_d;
  logic [WIDTH-1:0] tS1_q, tS1_d;
  logic [WIDTH-1:0] carry_q, carry_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             outValid_q, outValid_d;
  logic [WIDTH-1:0] outWord_q, outWord_d;
  logic             outLast_q, outLast_d;
  logic [WIDTH-1:0] topLo_q, topLo_d;
  logic [WIDTH-1:0] topHi_q, topHi_d;

  logic             canAdvance;
  logic             inReadyInt;
  logic             inBeat;
  logic             isLastIdx;
  logic [WIDTH-1:0] macT, macX, macS, macC;

  assign canAdvance = !outValid_q || out_ready;
  assign inReadyInt = (state_q == RUN) && canAdvance;
  assign inBeat     = in_valid && inReadyInt;
  assign isLastIdx  = (idx_q == LAST_IDX);

  // The tail fold-in reuses the word cell with a zero product: t_s + carry
  always_comb begin
    macT = in_t;
    macX = in_x;
    if (state_q == TAIL) begin
      macT = tS_q;
      macX = '0;
    end
  end

  cios_word_mac #(
    .WIDTH(WIDTH)
  ) u_mac (
    .t_i(macT),
    .x_i(macX),
    .y_i(scalar_q),
    .c_i(carry_q),
    .s_o(macS),
    .c_o(macC)
  );

  // Next-state logic for the row FSM, carry chain, output register and top words
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    scalar_d   = scalar_q;
    tS_d       = tS_q;
    tS1_d      = tS1_q;
    carry_d    = carry_q;
    idx_d      = idx_q;
    outValid_d = outValid_q;
    outWord_d  = outWord_q;
    outLast_d  = outLast_q;
    topLo_d    = topLo_q;
    topHi_d    = topHi_q;

    if (outValid_q && out_ready) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = RUN;
          mode_d   = cios_mode_e'(mode);
          scalar_d = scalar;
          tS_d     = t_s;
          tS1_d    = t_s1;
          carry_d  = '0;
          idx_d    = '0;
        end
      end
      RUN: begin
        if (inBeat) begin
          carry_d = macC;
          if (isLastIdx) begin
            state_d = TAIL;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
          if (mode_q == CIOS_MUL) begin
            outValid_d = 1'b1;
            outWord_d  = macS;
            outLast_d  = isLastIdx;
          end else if (idx_q != '0) begin
            outValid_d = 1'b1;
            outWord_d  = macS;
            outLast_d  = 1'b0;
          end
        end
      end
      TAIL: begin
        if (canAdvance) begin
          state_d = DONE;
          if (mode_q == CIOS_MUL) begin
            topLo_d = macS;
            topHi_d = macC;
          end else begin
            outValid_d = 1'b1;
            outWord_d  = macS;
            outLast_d  = 1'b1;
            topLo_d    = tS1_q + macC;
            topHi_d    = '0;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any row in flight and drops pending output
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      mode_q     <= CIOS_MUL;
      scalar_q   <= '0;
      tS_q       <= '0;
      tS1_q      <= '0;
      carry_q    <= '0;
      idx_q      <= '0;
      outValid_q <= 1'b0;
      outWord_q  <= '0;
      outLast_q  <= 1'b0;
      topLo_q    <= '0;
      topHi_q    <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      scalar_q   <= scalar_d;
      tS_q       <= tS_d;
      tS1_q      <= tS1_d;
      carry_q    <= carry_d;
      idx_q      <= idx_d;
      outValid_q <= outValid_d;
      outWord_q  <= outWord_d;
      outLast_q  <= outLast_d;
      topLo_q    <= topLo_d;
      topHi_q    <= topHi_d;
    end
  end

  assign in_ready  = inReadyInt;
  assign out_valid = outValid_q;
  assign out_word  = outWord_q;
  assign out_last  = outLast_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign top_lo    = topLo_q;
  assign top_hi    = topHi_q;

endmodule

// File: tb/tb_cios_row_engine.sv
// Directed, table-driven bench for cios_row_engine with WIDTH = 16, NUM_WORDS = 4.
module tb_cios_row_engine;

  localparam int W = 16;
  localparam int S = 4;

  typedef struct {
    logic              mode;
    logic [W-1:0]      scalar;
    logic [W-1:0]      ts;
    logic [W-1:0]      ts1;
    logic [S-1:0][W-1:0] x;
    logic [S-1:0][W-1:0] t;
    logic [S-1:0][W-1:0] expOut;
    logic [W-1:0]      expLo;
    logic [W-1:0]      expHi;
  } rowVec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic [W-1:0] scalar = '0;
  logic [W-1:0] t_s = '0;
  logic [W-1:0] t_s1 = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_x = '0;
  logic [W-1:0] in_t = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_word;
  logic         out_last;
  logic         busy;
  logic         done;
  logic [W-1:0] top_lo;
  logic [W-1:0] top_hi;

  int checks = 0;
  int failures = 0;
  int cycleCnt = 0;

  logic [W-1:0] outQ[$];
  logic         lastQ[$];
  int           outCount = 0;
  int           doneCount = 0;
  int           doneCycle = 0;
  int           firstOutCycle = 0;
  logic         seenOut = 1'b0;
  int           firstBeat = 0;
  int           totalRetries = 0;

  rowVec_t vecs[4];

  cios_row_engine #(
    .WIDTH(W),
    .NUM_WORDS(S)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .mode(mode),
    .scalar(scalar),
    .t_s(t_s),
    .t_s1(t_s1),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_x(in_x),
    .in_t(in_t),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_word(out_word),
    .out_last(out_last),
    .busy(busy),
    .done(done),
    .top_lo(top_lo),
    .top_hi(top_hi)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle index, so that events sampled on the falling edge can be timed
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Capture every accepted output word, the first valid cycle and each done pulse
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      outQ.push_back(out_word);
      lastQ.push_back(out_last);
      outCount = outCount + 1;
    end
    if (out_valid && !seenOut) begin
      seenOut = 1'b1;
      firstOutCycle = cycleCnt;
    end
    if (done) begin
      doneCount = doneCount + 1;
      doneCycle = cycleCnt;
    end
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s: actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, " ctrl"}, 32'({in_ready, out_valid, out_last, busy, done}), 32'd0);
    checkOutput({tag, " out_word"}, 32'(out_word), 32'd0);
    checkOutput({tag, " top_lo"}, 32'(top_lo), 32'd0);
    checkOutput({tag, " top_hi"}, 32'(top_hi), 32'd0);
  endtask

  // Run one row from vecs[vi]; optional output stall, start poke during RUN, or early abort
  task automatic applyStimulus(input int vi, input int stallLen, input logic pokeStart, input int abortAfter);
    rowVec_t v;
    int      doneBefore;
    v = vecs[vi];
    outQ.delete();
    lastQ.delete();
    outCount = 0;
    seenOut = 1'b0;
    firstBeat = -1;
    totalRetries = 0;
    doneBefore = doneCount;

    @(posedge clk); #1;
    mode = v.mode;
    scalar = v.scalar;
    t_s = v.ts;
    t_s1 = v.ts1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;

    fork
      begin : feeder
        for (int j = 0; j < S; j++) begin
          logic acc;
          if (abortAfter != 0 && j == abortAfter) break;
          in_valid = 1'b1;
          in_x = v.x[j];
          in_t = v.t[j];
          if (pokeStart && j == 1) begin
            start = 1'b1;
            mode = ~v.mode;
            scalar = '0;
            t_s = '0;
            t_s1 = '0;
          end
          acc = 1'b0;
          for (int r = 0; r < 60 && !acc; r++) begin
            @(negedge clk);
            if (j == 0 && r == 0) begin
              checkOutput($sformatf("row%0d busy after start", vi), 32'(busy), 32'd1);
              checkOutput($sformatf("row%0d in_ready after start", vi), 32'(in_ready), 32'd1);
            end
            if (in_ready) begin
              acc = 1'b1;
              if (j == 0) firstBeat = cycleCnt;
            end else begin
              totalRetries = totalRetries + 1;
            end
            @(posedge clk); #1;
            start = 1'b0;
          end
          if (!acc) begin
            checkOutput($sformatf("row%0d in-beat %0d accepted", vi, j), 32'd0, 32'd1);
            break;
          end
        end
        in_valid = 1'b0;
      end
      begin : staller
        if (stallLen > 0) begin
          int waited;
          waited = 0;
          while (outCount < 2 && waited < 60) begin
            @(posedge clk);
            waited = waited + 1;
          end
          #1;
          out_ready = 1'b0;
          for (int c = 0; c < stallLen; c++) begin
            @(negedge clk);
            checkOutput($sformatf("row%0d stall%0d out_valid", vi, c), 32'(out_valid), 32'd1);
            checkOutput($sformatf("row%0d stall%0d out_word held", vi, c), 32'(out_word), 32'(v.expOut[2]));
            checkOutput($sformatf("row%0d stall%0d in_ready", vi, c), 32'(in_ready), 32'd0);
          end
          @(posedge clk); #1;
          out_ready = 1'b1;
        end
      end
    join

    if (abortAfter == 0) begin
      for (int r = 0; r < 60 && doneCount == doneBefore; r++) @(posedge clk);
      checkOutput($sformatf("row%0d done timing", vi), 32'(doneCycle - firstBeat), 32'(5 + stallLen));
      checkOutput($sformatf("row%0d first out latency", vi), 32'(firstOutCycle - firstBeat),
                  v.mode ? 32'd2 : 32'd1);
      checkOutput($sformatf("row%0d stream length", vi), 32'(outQ.size()), 32'(S));
      for (int j = 0; j < S && j < outQ.size(); j++) begin
        checkOutput($sformatf("row%0d word%0d", vi, j), 32'(outQ[j]), 32'(v.expOut[j]));
        checkOutput($sformatf("row%0d last%0d", vi, j), 32'(lastQ[j]), (j == S - 1) ? 32'd1 : 32'd0);
      end
      @(negedge clk);
      checkOutput($sformatf("row%0d top_lo", vi), 32'(top_lo), 32'(v.expLo));
      checkOutput($sformatf("row%0d top_hi", vi), 32'(top_hi), 32'(v.expHi));
      @(posedge clk);
      checkOutput($sformatf("row%0d single done pulse", vi), 32'(doneCount - doneBefore), 32'd1);
      if (stallLen == 0) begin
        checkOutput($sformatf("row%0d in_ready gaps", vi), 32'(totalRetries), 32'd0);
      end
    end
  endtask

  initial begin
    int doneSnap;

    // MUL all-ones
    vecs[0] = '{mode: 1'b0, scalar: 16'hFFFF, ts: 16'hFFFF, ts1: 16'h0000,
                x: {4{16'hFFFF}}, t: {4{16'hFFFF}},
                expOut: {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000},
                expLo: 16'hFFFE, expHi: 16'h0001};
    // RED with tail carry
    vecs[1] = '{mode: 1'b1, scalar: 16'h0001, ts: 16'hFFFF, ts1: 16'h0001,
                x: {16'h0004, 16'h0003, 16'h0002, 16'h0001},
                t: {16'hFFFF, 16'h0006, 16'h0005, 16'hFFFF},
                expOut: {16'h0000, 16'h0003, 16'h0009, 16'h0008},
                expLo: 16'h0002, expHi: 16'h0000};
    // MUL small scalar, carry out of the last word folds into top_hi
    vecs[2] = '{mode: 1'b0, scalar: 16'h0002, ts: 16'hFFFF, ts1: 16'h1234,
                x: {16'h8000, 16'h0003, 16'h0002, 16'h0001},
                t: {16'h0000, 16'h0000, 16'h0010, 16'h0000},
                expOut: {16'h0000, 16'h0006, 16'h0014, 16'h0002},
                expLo: 16'h0000, expHi: 16'h0001};
    // RED where t_s1 + C' wraps to zero
    vecs[3] = '{mode: 1'b1, scalar: 16'h0003, ts: 16'hFFFF, ts1: 16'hFFFF,
                x: {16'h0001, 16'h0000, 16'h0001, 16'h5555},
                t: {16'hFFFF, 16'h0000, 16'h0000, 16'h0001},
                expOut: {16'h0000, 16'h0002, 16'h0000, 16'h0004},
                expLo: 16'h0000, expHi: 16'h0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetOutputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      applyStimulus(i, 0, 1'b0, 0);
    end

    $display("[TB] backpressure row");
    applyStimulus(0, 3, 1'b0, 0);

    $display("[TB] start during RUN");
    applyStimulus(0, 0, 1'b1, 0);

    $display("[TB] reset mid-row");
    doneSnap = doneCount;
    applyStimulus(1, 0, 1'b0, 2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checkResetOutputs("mid-row reset");
    repeat (10) @(posedge clk);
    checkOutput("no done after abort", 32'(doneCount - doneSnap), 32'd0);
    applyStimulus(1, 0, 1'b0, 0);

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
